// File: rtl/ysyx_23060077_regfile_sb.sv
// ysyx_23060077_regfile_sb: integer register file with per-register busy scoreboard,
// same-cycle writeback bypass and RAW/WAW issue stall. Rev 1.0
`default_nettype none

module ysyx_23060077_regfile_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_NUM    = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  issue_valid,
  input  logic                  issue_rd_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic                  rs1_en,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic                  rs2_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  issue_ready,
  output logic [REG_NUM-1:0]    busy_vec
);

  // x0 has no storage at all; every lookup below only matches indices 1..REG_NUM-1.
  logic [DATA_WIDTH-1:0] regs [1:REG_NUM-1];
  logic [REG_NUM-1:0]    busy;
  logic [REG_NUM-1:0]    busy_next;
  logic                  haz1;
  logic                  haz2;
  logic                  waw;
  logic                  fire;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    in_range = 1'b0;
    for (int i = 1; i < REG_NUM; i++)
      if (a == ADDR_WIDTH'(i)) in_range = 1'b1;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] reg_at(input logic [ADDR_WIDTH-1:0] a);
    reg_at = '0;
    for (int i = 1; i < REG_NUM; i++)
      if (a == ADDR_WIDTH'(i)) reg_at = regs[i];
  endfunction

  function automatic logic busy_at(input logic [ADDR_WIDTH-1:0] a);
    busy_at = 1'b0;
    for (int i = 1; i < REG_NUM; i++)
      if (a == ADDR_WIDTH'(i)) busy_at = busy[i];
  endfunction

  function automatic logic wb_hit(input logic [ADDR_WIDTH-1:0] a);
    wb_hit = wb_en && (wb_rd == a);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] a);
    if (!in_range(a))  read_port = '0;
    else if (wb_hit(a)) read_port = wb_data;
    else               read_port = reg_at(a);
  endfunction

  // A writeback landing this cycle resolves the hazard it would otherwise cause.
  function automatic logic pending(input logic en, input logic [ADDR_WIDTH-1:0] a);
    pending = en && in_range(a) && busy_at(a) && !wb_hit(a);
  endfunction

  always_comb begin
    haz1        = pending(rs1_en, rs1_addr);
    haz2        = pending(rs2_en, rs2_addr);
    waw         = pending(issue_rd_en, issue_rd);
    rs1_data    = '0;
    rs2_data    = '0;
    issue_ready = 1'b1;
    if (!reset) begin
      rs1_data    = read_port(rs1_addr);
      rs2_data    = read_port(rs2_addr);
      issue_ready = !(haz1 || haz2 || waw || flush);
    end
    fire = issue_valid && issue_ready && !reset;
  end

  // Set after clear so a new producer issuing against a retiring one keeps the bit.
  always_comb begin
    busy_next = busy;
    for (int i = 1; i < REG_NUM; i++)
      if (wb_hit(ADDR_WIDTH'(i))) busy_next[i] = 1'b0;
    if (flush) begin
      busy_next = '0;
    end else if (fire && issue_rd_en) begin
      for (int i = 1; i < REG_NUM; i++)
        if (issue_rd == ADDR_WIDTH'(i)) busy_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < REG_NUM; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      for (int i = 1; i < REG_NUM; i++)
        if (wb_hit(ADDR_WIDTH'(i))) regs[i] <= wb_data;
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060077_regfile_sb.sv
// tb_ysyx_23060077_regfile_sb: directed literal checks plus randomized traffic
// compared every cycle against an array-based reference model.
`default_nettype none

module tb_ysyx_23060077_regfile_sb;
  logic        clock = 1'b0;
  logic        reset;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        issue_valid, issue_rd_en;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_en, rs2_en, flush;
  logic [31:0] rs1_data, rs2_data;
  logic        issue_ready;
  logic [31:0] busy_vec;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_reg  [32];
  logic        m_busy [32];

  ysyx_23060077_regfile_sb dut (
    .clock(clock), .reset(reset), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_valid(issue_valid), .issue_rd_en(issue_rd_en), .issue_rd(issue_rd),
    .rs1_addr(rs1_addr), .rs1_en(rs1_en), .rs2_addr(rs2_addr), .rs2_en(rs2_en),
    .flush(flush), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_ready(issue_ready), .busy_vec(busy_vec)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (reset || a == 5'd0) return 32'd0;
    if (wb_en && wb_rd == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic logic m_stall(input logic en, input logic [4:0] a);
    return en && a != 5'd0 && m_busy[a] && !(wb_en && wb_rd == a);
  endfunction

  function automatic logic m_ready();
    if (reset) return 1'b1;
    if (flush) return 1'b0;
    return !(m_stall(rs1_en, rs1_addr) || m_stall(rs2_en, rs2_addr) ||
             m_stall(issue_rd_en, issue_rd));
  endfunction

  function automatic logic [31:0] m_busy_vec();
    logic [31:0] v = '0;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      logic fire;
      fire = issue_valid && m_ready();
      if (wb_en && wb_rd != 5'd0) begin
        m_reg[wb_rd]  = wb_data;
        m_busy[wb_rd] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (fire && issue_rd_en && issue_rd != 5'd0) begin
        m_busy[issue_rd] = 1'b1;
      end
    end
  end

  // Compare process: mid-cycle, inputs and state both settled.
  always @(negedge clock) begin
    chk("rs1_data", {32'd0, rs1_data}, {32'd0, m_read(rs1_addr)});
    chk("rs2_data", {32'd0, rs2_data}, {32'd0, m_read(rs2_addr)});
    chk("issue_ready", {63'd0, issue_ready}, {63'd0, m_ready()});
    chk("busy_vec", {32'd0, busy_vec}, {32'd0, m_busy_vec()});
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    wb_en = 0; wb_rd = 0; wb_data = 0;
    issue_valid = 0; issue_rd_en = 0; issue_rd = 0;
    rs1_addr = 0; rs1_en = 0; rs2_addr = 0; rs2_en = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1; issue_rd_en = 1; issue_rd = rd;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_en = 1; wb_rd = rd; wb_data = d;
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
  endfunction

  initial begin
    idle();
    reset = 1;
    rs1_addr = 5; rs2_addr = 31; rs1_en = 1; rs2_en = 1;
    #3;
    chk("reset_rs1", {32'd0, rs1_data}, 64'd0);
    chk("reset_rs2", {32'd0, rs2_data}, 64'd0);
    chk("reset_ready", {63'd0, issue_ready}, 64'd1);
    chk("reset_busy", {32'd0, busy_vec}, 64'd0);
    step(); step();
    reset = 0;

    // Bypass, then array read.
    wb(3, 32'hDEADBEEF); rs1_addr = 3; rs1_en = 1;
    #2 chk("bypass_x3", {32'd0, rs1_data}, 64'hDEADBEEF);
    step(); rs1_addr = 3; rs1_en = 1;
    #2 chk("array_x3", {32'd0, rs1_data}, 64'hDEADBEEF);

    // RAW stall on x7 resolved by writeback.
    step(); issue(7);
    step(); rs2_addr = 7; rs2_en = 1;
    #2 chk("raw_stall", {63'd0, issue_ready}, 64'd0);
    chk("busy7_set", {32'd0, busy_vec}, 64'h80);
    step(); rs2_addr = 7; rs2_en = 1; wb(7, 32'h12);
    #2 chk("raw_wb_ready", {63'd0, issue_ready}, 64'd1);
    chk("raw_wb_bypass", {32'd0, rs2_data}, 64'h12);
    step();
    #2 chk("busy7_clear", {32'd0, busy_vec}, 64'd0);

    // x0 never busy, never written.
    issue(0); wb(0, 32'h55); rs1_addr = 0; rs1_en = 1;
    #2 chk("x0_read", {32'd0, rs1_data}, 64'd0);
    step();
    #2 chk("x0_busy", {32'd0, busy_vec}, 64'd0);

    // Same-cycle retire and reissue of x9.
    issue(9);
    step(); issue(9); wb(9, 32'h99);
    #2 chk("reissue_ready", {63'd0, issue_ready}, 64'd1);
    step(); rs1_addr = 9;
    #2 chk("reissue_busy", {32'd0, busy_vec}, 64'h200);
    chk("reissue_data", {32'd0, rs1_data}, 64'h99);
    wb(9, 32'h98);

    // Flush with concurrent writeback.
    step(); issue(4);
    step(); issue(8);
    step();
    #2 chk("busy_4_8", {32'd0, busy_vec}, 64'h110);
    flush = 1; wb(4, 32'hA5); issue(10);
    #2 chk("flush_ready", {63'd0, issue_ready}, 64'd0);
    step(); rs1_addr = 4;
    #2 chk("flush_busy", {32'd0, busy_vec}, 64'd0);
    chk("flush_wb", {32'd0, rs1_data}, 64'hA5);
    issue(6);

    // Asynchronous reset between edges.
    step(); rs1_addr = 4; rs2_addr = 3;
    #1 reset = 1;
    #1 chk("async_busy", {32'd0, busy_vec}, 64'd0);
    chk("async_rs1", {32'd0, rs1_data}, 64'd0);
    step(); reset = 0; rs1_addr = 4; rs2_addr = 3;
    #2 chk("post_reset_x4", {32'd0, rs1_data}, 64'd0);
    chk("post_reset_x3", {32'd0, rs2_data}, 64'd0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step();
      wb_en       = ($urandom_range(0, 2) != 0);
      wb_rd       = rnd_addr();
      wb_data     = $urandom;
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_rd_en = ($urandom_range(0, 4) != 0);
      issue_rd    = rnd_addr();
      rs1_addr    = rnd_addr();
      rs1_en      = $urandom_range(0, 1);
      rs2_addr    = rnd_addr();
      rs2_en      = $urandom_range(0, 1);
      flush       = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #1 reset = 1;
        #2 reset = 0;
      end
    end

    step();
    @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/ysyx_23060077_regfile_sb.md
Name: ysyx_23060077_regfile_sb

Overview:
- Architectural integer register file plus per-register busy scoreboard. It is the receiving end of the writeback path: it consumes the writeback result and destination, and serves operands to the decode/issue stage.
- Issue marks a destination register busy. Writeback writes the data and clears busy.
- Read ports return register data with same-cycle writeback bypass and raise a stall on RAW/WAW hazards.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- REG_NUM, 32, number of architectural registers (16 for RV32E builds).
- ADDR_WIDTH, 5, register index width; must satisfy 2**ADDR_WIDTH >= REG_NUM.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- wb_en  in  1  writeback valid this cycle.
- wb_rd  in  ADDR_WIDTH  writeback destination index.
- wb_data  in  DATA_WIDTH  writeback value (final selected result from the writeback unit).
- issue_valid  in  1  decode requests issue of one instruction this cycle.
- issue_rd_en  in  1  the issuing instruction writes a register.
- issue_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- rs1_addr  in  ADDR_WIDTH  source 1 index.
- rs1_en  in  1  source 1 is used.
- rs2_addr  in  ADDR_WIDTH  source 2 index.
- rs2_en  in  1  source 2 is used.
- flush  in  1  pipeline redirect; discards all outstanding producers.
- rs1_data  out  DATA_WIDTH  source 1 operand (combinational).
- rs2_data  out  DATA_WIDTH  source 2 operand (combinational).
- issue_ready  out  1  issue may proceed (no hazard); combinational.
- busy_vec  out  REG_NUM  current busy bits, for debug/difftest.

Behaviour:
- Reset (async, active-high): all registers = 0; all busy bits = 0.
  - Outputs during reset: rs*_data = 0, issue_ready = 1, busy_vec = 0.
  - Reset mid-operation discards pending writes and busy state immediately.
- Register x0:
  - Always reads 0.
  - Writes to index 0 are ignored.
  - Never marked busy.
  - Never causes a stall.
- Writeback: if wb_en and wb_rd != 0, reg[wb_rd] <= wb_data at the clock edge, and busy[wb_rd] clears (except as ruled below).
- Read, combinational:
  - If rsN_addr == 0 -> 0.
  - Else if wb_en and wb_rd == rsN_addr -> wb_data (bypass).
  - Else -> reg[rsN_addr].
  - rsN_addr >= REG_NUM reads 0.
- Hazard per source: hazN = rsN_en and rsN_addr != 0 and busy[rsN_addr] and not (wb_en and wb_rd == rsN_addr).
- WAW hazard: issue_rd_en and issue_rd != 0 and busy[issue_rd] and not (wb_en and wb_rd == issue_rd).
- issue_ready = not (haz1 or haz2 or waw) and not flush.
  - issue_ready does not depend on issue_valid (no combinational loop).
- Issue fires when issue_valid and issue_ready. If issue_rd_en and issue_rd != 0, busy[issue_rd] <= 1.
- Simultaneous issue fire and writeback to the same rd: busy ends 1 (the new producer wins). The data write still occurs.
- Flush:
  - All busy bits <= 0.
  - No issue fires that cycle.
  - A writeback in the same cycle still writes data.
- Latency:
  - Write becomes visible through the array the cycle after wb_en; visible the same cycle via bypass.
  - Busy set is visible the cycle after issue.
- At most one in-flight producer per register (guaranteed by the WAW stall); no counters.

Test Plan:
- Reset then read rs1=5, rs2=31 -> both 0, issue_ready=1, busy_vec=0.
- wb_en=1, wb_rd=3, wb_data=0xDEADBEEF; same cycle rs1=3 -> rs1_data=0xDEADBEEF (bypass). Next cycle with wb_en=0 -> still 0xDEADBEEF.
- Issue rd=7. Next cycle rs2=7, rs2_en=1 -> issue_ready=0. Cycle with wb_en, wb_rd=7, wb_data=0x12 -> issue_ready=1, rs2_data=0x12, and busy[7]=0 afterwards.
- Issue rd=0 and wb_rd=0 with data 0x55 -> busy_vec=0, rs1=0 reads 0.
- busy[9]=1; same cycle wb_rd=9 and issue rd=9 fires -> reg[9] updated, busy[9] remains 1.
- busy set on x4 and x8; flush=1 with wb_rd=4, wb_data=0xA5 -> issue_ready=0 that cycle; next cycle busy_vec=0, reg[4]=0xA5. Assert reset mid-sequence -> all registers 0 immediately, without a clock edge.
